simd_shifter_arb: RTL and testbench

Round-robin arbiter and two-stage pipeline that shares one `simd_shifter` datapath instance between `N` requesters. It accepts shift commands on per-requester valid/ready ports and registers the winner into an issue stage that drives the shifter. It captures the shifter result into a response stage, returning it tagged with the requester index under valid/ready backpressure. It sits between the SIMD issue ports and the single shared shifter, which is instantiated outside this block.

---
 rtl/simd_shifter_arb_if.sv | 46 ++++
 rtl/simd_shifter_arb.sv | 145 ++++++++++++++
 tb/tb_simd_shifter_arb.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_shifter_arb_if.sv
// Bundle of the requester command ports, the shared shifter link and the
// response port of simd_shifter_arb. The arbiter takes the slave view; the
// surrounding logic (requesters, shifter, response consumer) takes master.
interface simd_shifter_arb_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  // Requester command ports, one lane per requester
  logic [N-1:0]             req_vld;
  logic [N-1:0]             req_rdy;
  logic [N-1:0][63:0]       req_in;
  logic [N-1:0][1:0]        req_mode;
  logic [N-1:0][1:0]        req_op;
  logic [N-1:0][7:0][5:0]   req_shift;

  // Command presented to the shared shifter and its combinational result
  logic [63:0]              sh_in;
  logic [1:0]               sh_mode;
  logic [1:0]               sh_op;
  logic [7:0][5:0]          sh_shift;
  logic [63:0]              sh_out;

  // Tagged response port
  logic                     rsp_vld;
  logic                     rsp_rdy;
  logic [IDW-1:0]           rsp_id;
  logic [63:0]              rsp_data;

  modport master (
    output req_vld, req_in, req_mode, req_op, req_shift,
    input  req_rdy,
    input  sh_in, sh_mode, sh_op, sh_shift,
    output sh_out,
    input  rsp_vld, rsp_id, rsp_data,
    output rsp_rdy
  );

  modport slave (
    input  req_vld, req_in, req_mode, req_op, req_shift,
    output req_rdy,
    output sh_in, sh_mode, sh_op, sh_shift,
    input  sh_out,
    output rsp_vld, rsp_id, rsp_data,
    input  rsp_rdy
  );
endinterface

// File: rtl/simd_shifter_arb.sv
// Round-robin arbiter plus two-stage issue/response pipeline that shares one
// external SIMD shifter between N requesters. S1 holds the granted command and
// drives the shifter; S2 captures the shifter result and presents it, tagged
// with the requester index, under valid/ready backpressure. Command fields are
// passed through untouched: all shift semantics live in the shifter.
module simd_shifter_arb #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  simd_shifter_arb_if.slave bus,
  output logic              busy
);

  // Issue stage (S1)
  logic                 s1_vld_reg;
  logic [IDW-1:0]       s1_id_reg;
  logic [63:0]          s1_in_reg;
  logic [1:0]           s1_mode_reg;
  logic [1:0]           s1_op_reg;
  logic [7:0][5:0]      s1_shift_reg;

  // Response stage (S2)
  logic                 s2_vld_reg;
  logic [IDW-1:0]       s2_id_reg;
  logic [63:0]          s2_data_reg;

  // Index of the most recently granted requester
  logic [IDW-1:0]       ptr_reg;

  logic                 s2_adv;
  logic                 s1_adv;

  // Requesters in priority order: entry gi is (ptr+1+gi) mod N
  logic [IDW-1:0]       cand_id [N];
  logic [N-1:0]         cand_vld;

  logic                 gnt_any;
  logic [IDW-1:0]       gnt_id;
  logic [N-1:0]         gnt;
  logic                 take;

  // S2 can move when it is empty or being drained; S1 can move when it is
  // empty or S2 is about to take its contents.
  assign s2_adv = !s2_vld_reg || bus.rsp_rdy;
  assign s1_adv = !s1_vld_reg || s2_adv;

  genvar gi;

  // Rotate the request vector so that position 0 is the requester after ptr.
  // The sum is one bit wider so the wrap needs a single conditional subtract.
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum          = {1'b0, ptr_reg} + (IDW+1)'(gi + 1);
      assign cand_id[gi]  = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N))
                                                 : sum[IDW-1:0];
      assign cand_vld[gi] = bus.req_vld[cand_id[gi]];
    end
  endgenerate

  // Pick the first valid requester in rotated order (lowest position wins)
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        gnt_any = 1'b1;
        gnt_id  = cand_id[k];
      end
    end
  end

  // One-hot ready, only offered when S1 can accept; held low during reset
  // so no requester sees an accept that the registers would ignore.
  generate
    for (gi = 0; gi < N; gi++) begin : g_gnt
      assign gnt[gi] = rst_n && s1_adv && gnt_any && (gnt_id == IDW'(gi));
    end
  endgenerate

  assign take        = s1_adv && gnt_any;
  assign bus.req_rdy = gnt;

  // Issue stage: load the granted command, or drain to empty without a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_reg   <= 1'b0;
      s1_id_reg    <= '0;
      s1_in_reg    <= '0;
      s1_mode_reg  <= '0;
      s1_op_reg    <= '0;
      s1_shift_reg <= '0;
    end else if (s1_adv) begin
      s1_vld_reg <= take;
      // Payload is only replaced on a real grant so sh_* stay quiet when idle
      if (take) begin
        s1_id_reg    <= gnt_id;
        s1_in_reg    <= bus.req_in[gnt_id];
        s1_mode_reg  <= bus.req_mode[gnt_id];
        s1_op_reg    <= bus.req_op[gnt_id];
        s1_shift_reg <= bus.req_shift[gnt_id];
      end
    end
  end

  // Response stage: capture the shifter result for the command in S1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_reg  <= 1'b0;
      s2_id_reg   <= '0;
      s2_data_reg <= '0;
    end else if (s2_adv) begin
      s2_vld_reg <= s1_vld_reg;
      // Tag and data keep their last value when a bubble moves through
      if (s1_vld_reg) begin
        s2_id_reg   <= s1_id_reg;
        s2_data_reg <= bus.sh_out;
      end
    end
  end

  // Round-robin pointer: remember the requester that completed a handshake.
  // Resetting to N-1 makes requester 0 the first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= IDW'(N - 1);
    end else if (take) begin
      ptr_reg <= gnt_id;
    end
  end

  assign bus.sh_in    = s1_in_reg;
  assign bus.sh_mode  = s1_mode_reg;
  assign bus.sh_op    = s1_op_reg;
  assign bus.sh_shift = s1_shift_reg;

  assign bus.rsp_vld  = s2_vld_reg;
  assign bus.rsp_id   = s2_id_reg;
  assign bus.rsp_data = s2_data_reg;

  assign busy = s1_vld_reg || s2_vld_reg;

endmodule

// File: tb/tb_simd_shifter_arb.sv
// Self-checking bench for simd_shifter_arb: directed scenarios plus random
// traffic, with a transaction-level pipeline model and a behavioural shifter.
module tb_simd_shifter_arb;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk;
  logic rst_n;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  simd_shifter_arb_if #(.N(N), .IDW(IDW)) bus();

  simd_shifter_arb #(.N(N), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SIMD shifter: mode 0..3 = 64/32/16/8-bit lanes; op 0/2 left,
  // 1 logical right, 3 arithmetic right; over-wide shifts give 0 / sign fill.
  function automatic logic [63:0] shift_ref(input logic [63:0] din, input logic [1:0] mode,
                                            input logic [1:0] op, input logic [7:0][5:0] amt);
    int lw, nl;
    logic [63:0] mask, v, r, res;
    lw   = 64 >> mode;
    nl   = 64 / lw;
    mask = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
    res  = '0;
    for (int k = 0; k < nl; k++) begin
      v = (din >> (k * lw)) & mask;
      case (op)
        2'd0, 2'd2: r = (v << amt[k]) & mask;
        2'd1:       r = v >> amt[k];
        default: begin
          if (v[lw-1]) v = v | ~mask;
          r = 64'($signed(v) >>> amt[k]) & mask;
        end
      endcase
      res = res | (r << (k * lw));
    end
    return res;
  endfunction

  assign bus.sh_out = shift_ref(bus.sh_in, bus.sh_mode, bus.sh_op, bus.sh_shift);

  task automatic set_payload(input int i);
    bus.req_in[i]   = {$urandom, $urandom};
    bus.req_mode[i] = 2'($urandom_range(0, 3));
    bus.req_op[i]   = 2'($urandom_range(0, 3));
    for (int j = 0; j < 8; j++) bus.req_shift[i][j] = 6'($urandom);
  endtask

  // ---------------- transaction-level model and monitor ----------------
  typedef struct {
    int              id;
    logic [63:0]     din;
    logic [1:0]      mode;
    logic [1:0]      op;
    logic [7:0][5:0] amt;
    int              stage;   // 1 = presented to shifter, 2 = presented as response
  } cmd_t;

  cmd_t        pipe[$];
  cmd_t        m_c;
  int          m_ptr;
  int          m_g;
  bit          m_s1, m_s2, m_s1adv, m_s2adv;
  logic [N-1:0] m_gnt;

  initial begin
    m_ptr = N - 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pipe.delete();
        m_ptr = N - 1;
      end else begin
        m_s2    = (pipe.size() > 0) && (pipe[0].stage == 2);
        m_s1    = (pipe.size() > 0) && (pipe[pipe.size()-1].stage == 1);
        m_s2adv = !m_s2 || bus.rsp_rdy;
        m_s1adv = !m_s1 || m_s2adv;
        m_gnt   = '0;
        m_g     = -1;
        if (m_s1adv) begin
          for (int k = 1; k <= N; k++)
            if (m_g < 0 && bus.req_vld[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        end
        if (m_g >= 0) m_gnt[m_g] = 1'b1;

        n_checks++;
        if (bus.req_rdy !== m_gnt) begin
          n_fail++;
          $display("FAIL mon_req_rdy t=%0t: got %b expected %b", $time, bus.req_rdy, m_gnt);
        end
        n_checks++;
        if (bus.rsp_vld !== m_s2) begin
          n_fail++;
          $display("FAIL mon_rsp_vld t=%0t: got %b expected %b", $time, bus.rsp_vld, m_s2);
        end
        n_checks++;
        if (busy !== (pipe.size() > 0)) begin
          n_fail++;
          $display("FAIL mon_busy t=%0t: got %b expected %b", $time, busy, pipe.size() > 0);
        end
        if (m_s2) begin
          n_checks++;
          if (bus.rsp_id !== IDW'(pipe[0].id)) begin
            n_fail++;
            $display("FAIL mon_rsp_id t=%0t: got %0d expected %0d", $time, bus.rsp_id, pipe[0].id);
          end
          n_checks++;
          if (bus.rsp_data !== shift_ref(pipe[0].din, pipe[0].mode, pipe[0].op, pipe[0].amt)) begin
            n_fail++;
            $display("FAIL mon_rsp_data t=%0t: got %h expected %h", $time, bus.rsp_data,
                     shift_ref(pipe[0].din, pipe[0].mode, pipe[0].op, pipe[0].amt));
          end
        end
        if (m_s1) begin
          m_c = pipe[pipe.size()-1];
          n_checks++;
          if ({bus.sh_in, bus.sh_mode, bus.sh_op, bus.sh_shift} !== {m_c.din, m_c.mode, m_c.op, m_c.amt}) begin
            n_fail++;
            $display("FAIL mon_sh_cmd t=%0t: got %h/%0d/%0d/%h expected %h/%0d/%0d/%h", $time,
                     bus.sh_in, bus.sh_mode, bus.sh_op, bus.sh_shift, m_c.din, m_c.mode, m_c.op, m_c.amt);
          end
        end

        // Advance the model to the state after the coming clock edge
        if (m_s2 && bus.rsp_rdy) void'(pipe.pop_front());
        if (m_s1 && m_s2adv) begin
          m_c = pipe.pop_back();
          m_c.stage = 2;
          pipe.push_back(m_c);
        end
        if (m_g >= 0) begin
          m_c.id    = m_g;
          m_c.din   = bus.req_in[m_g];
          m_c.mode  = bus.req_mode[m_g];
          m_c.op    = bus.req_op[m_g];
          m_c.amt   = bus.req_shift[m_g];
          m_c.stage = 1;
          pipe.push_back(m_c);
          m_ptr = m_g;
          $display("txn t=%0t grant req=%0d in=%h mode=%0d op=%0d", $time, m_g, m_c.din, m_c.mode, m_c.op);
        end
      end
    end
  end

  // ---------------- directed and random scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    bus.rsp_rdy = 1'b1;
    bus.req_vld = '1;
    for (int i = 0; i < N; i++) set_payload(i);
    #3 rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_rdy !== '0) begin n_fail++; $display("FAIL reset_req_rdy: got %b expected 0", bus.req_rdy); end
    n_checks++;
    if (bus.rsp_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_vld: got %b expected 0", bus.rsp_vld); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (bus.rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
    n_checks++;
    if (bus.rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
    n_checks++;
    if ({bus.sh_in, bus.sh_mode, bus.sh_op, bus.sh_shift} !== '0) begin
      n_fail++;
      $display("FAIL reset_sh: got %h/%0d/%0d/%h expected 0", bus.sh_in, bus.sh_mode, bus.sh_op, bus.sh_shift);
    end
    @(posedge clk); #1;
    bus.req_vld = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b1;
    bus.req_vld = '0;
    bus.req_vld[0]   = 1'b1;
    bus.req_in[0]    = 64'h0000_0000_0000_00F0;
    bus.req_mode[0]  = 2'd3;
    bus.req_op[0]    = 2'd0;
    bus.req_shift[0] = '0;
    bus.req_shift[0][0] = 6'd1;
    @(negedge clk);
    n_checks++;
    if (bus.req_rdy !== 4'b0001) begin n_fail++; $display("FAIL single_req_rdy: got %b expected 0001", bus.req_rdy); end
    @(posedge clk); #1;
    bus.req_vld[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.sh_in !== 64'h0000_0000_0000_00F0) begin n_fail++; $display("FAIL single_sh_in: got %h expected f0", bus.sh_in); end
    n_checks++;
    if (bus.rsp_vld !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp: got %b expected 0", bus.rsp_vld); end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_vld !== 1'b1) begin n_fail++; $display("FAIL single_rsp_vld: got %b expected 1", bus.rsp_vld); end
    n_checks++;
    if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id: got %0d expected 0", bus.rsp_id); end
    n_checks++;
    if (bus.rsp_data !== 64'h0000_0000_0000_00E0) begin
      n_fail++; $display("FAIL single_rsp_data: got %h expected 00000000000000e0", bus.rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_sra();
    logic [63:0] exp_data;
    exp_data = 64'hF800_0000_0000_0000;
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b1;
    bus.req_vld = '0;
    bus.req_vld[2]   = 1'b1;
    bus.req_in[2]    = 64'h8000_0000_0000_0000;
    bus.req_mode[2]  = 2'd0;
    bus.req_op[2]    = 2'd3;
    bus.req_shift[2] = '0;
    bus.req_shift[2][0] = 6'd4;
    @(negedge clk);
    n_checks++;
    if (bus.req_rdy !== 4'b0100) begin n_fail++; $display("FAIL sra_req_rdy: got %b expected 0100", bus.req_rdy); end
    @(posedge clk); #1;
    bus.req_vld[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.rsp_vld !== 1'b1 || bus.rsp_id !== 2'd2) begin
      n_fail++; $display("FAIL sra_rsp_id: got vld=%b id=%0d expected vld=1 id=2", bus.rsp_vld, bus.rsp_id);
    end
    n_checks++;
    if (bus.rsp_data !== exp_data) begin n_fail++; $display("FAIL sra_rsp_data: got %h expected %h", bus.rsp_data, exp_data); end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int cnt [N];
    logic [N-1:0] hs;
    logic [N-1:0] exp_g;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_vld = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp_rdy = 1'b1;
    for (int i = 0; i < N; i++) set_payload(i);
    bus.req_vld = '1;
    for (int c = 0; c < 4 * N; c++) begin
      @(negedge clk);
      exp_g = '0;
      exp_g[c % N] = 1'b1;
      n_checks++;
      if (bus.req_rdy !== exp_g) begin n_fail++; $display("FAIL fair_grant c=%0d: got %b expected %b", c, bus.req_rdy, exp_g); end
      for (int i = 0; i < N; i++) cnt[i] += int'(bus.req_rdy[i]);
      if (c >= 2) begin
        n_checks++;
        if (bus.rsp_vld !== 1'b1 || bus.rsp_id !== IDW'((c - 2) % N)) begin
          n_fail++;
          $display("FAIL fair_rsp c=%0d: got vld=%b id=%0d expected vld=1 id=%0d", c, bus.rsp_vld, bus.rsp_id, (c - 2) % N);
        end
      end
      hs = bus.req_vld & bus.req_rdy;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (hs[i]) set_payload(i);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (cnt[i] !== 4) begin n_fail++; $display("FAIL fair_count req=%0d: got %0d expected 4", i, cnt[i]); end
    end
    bus.req_vld = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int ids[$];
    int hs_cnt;
    logic [63:0] hold_data, hold_sh;
    hs_cnt = 0;
    @(posedge clk); #1;
    bus.req_vld = '0;
    bus.rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.rsp_rdy = 1'b0;
    set_payload(1);
    set_payload(3);
    bus.req_vld[1] = 1'b1;
    bus.req_vld[3] = 1'b1;
    hold_data = '0;
    hold_sh   = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req_vld[i] && bus.req_rdy[i]) begin
          hs_cnt++;
          ids.push_back(i);
        end
      end
      if (c == 2) begin
        hold_data = bus.rsp_data;
        hold_sh   = bus.sh_in;
      end
      if (c == 5) begin
        n_checks++;
        if (bus.req_rdy !== '0) begin n_fail++; $display("FAIL bp_stall: got req_rdy=%b expected 0", bus.req_rdy); end
        n_checks++;
        if (bus.rsp_data !== hold_data || bus.sh_in !== hold_sh) begin
          n_fail++;
          $display("FAIL bp_hold: got %h/%h expected %h/%h", bus.rsp_data, bus.sh_in, hold_data, hold_sh);
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (ids.size() > 0 && ids[ids.size()-1] == i && c < 2) set_payload(i);
    end
    n_checks++;
    if (hs_cnt !== 2) begin n_fail++; $display("FAIL bp_handshakes: got %0d expected 2", hs_cnt); end
    bus.rsp_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_vld !== 1'b1 || ids.size() < 2 || bus.rsp_id !== IDW'(ids[0])) begin
      n_fail++; $display("FAIL bp_first_rsp: got vld=%b id=%0d expected first granted id", bus.rsp_vld, bus.rsp_id);
    end
    n_checks++;
    if (bus.req_rdy === '0) begin n_fail++; $display("FAIL bp_no_bubble: got req_rdy=%b expected a grant", bus.req_rdy); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_vld !== 1'b1 || ids.size() < 2 || bus.rsp_id !== IDW'(ids[1])) begin
      n_fail++; $display("FAIL bp_second_rsp: got vld=%b id=%0d expected second granted id", bus.rsp_vld, bus.rsp_id);
    end
    @(posedge clk); #1;
    bus.req_vld = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b0;
    set_payload(0);
    set_payload(2);
    bus.req_vld = '0;
    bus.req_vld[0] = 1'b1;
    bus.req_vld[2] = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (busy !== 1'b1 || bus.rsp_vld !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_full: got busy=%b rsp_vld=%b expected 1/1", busy, bus.rsp_vld);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp_vld: got %b expected 0", bus.rsp_vld); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    bus.req_vld = '0;
    bus.req_vld[0] = 1'b1;
    bus.req_vld[3] = 1'b1;
    set_payload(3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_rdy !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first_grant: got %b expected 0001", bus.req_rdy); end
    @(posedge clk); #1;
    bus.req_vld = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_withdraw();
    int n_rsp;
    n_rsp = 0;
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b0;
    bus.req_vld = '0;
    set_payload(0);
    bus.req_vld[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.req_rdy !== 4'b0001) begin n_fail++; $display("FAIL wd_fill c=%0d: got %b expected 0001", c, bus.req_rdy); end
      @(posedge clk); #1;
      set_payload(0);
    end
    bus.req_vld[0] = 1'b0;
    set_payload(1);
    bus.req_vld[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.req_rdy !== '0) begin n_fail++; $display("FAIL wd_stalled c=%0d: got %b expected 0", c, bus.req_rdy); end
      @(posedge clk); #1;
    end
    bus.req_vld[1] = 1'b0;
    set_payload(2);
    bus.req_vld[2] = 1'b1;
    bus.rsp_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_rdy !== 4'b0100) begin n_fail++; $display("FAIL wd_regrant: got %b expected 0100", bus.req_rdy); end
    if (bus.rsp_vld) n_rsp++;
    @(posedge clk); #1;
    bus.req_vld[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.rsp_vld) n_rsp++;
      n_checks++;
      if (bus.rsp_vld && bus.rsp_id === 2'd1) begin n_fail++; $display("FAIL wd_ghost_rsp: got rsp_id=1 expected no response for 1"); end
    end
    n_checks++;
    if (n_rsp !== 3) begin n_fail++; $display("FAIL wd_rsp_count: got %0d expected 3", n_rsp); end
  endtask

  task automatic test_random();
    logic [N-1:0] hs;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      hs = bus.req_vld & bus.req_rdy;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !bus.req_vld[i]) begin
          bus.req_vld[i] = ($urandom_range(0, 99) < 60);
          if (bus.req_vld[i]) set_payload(i);
        end else if ($urandom_range(0, 99) < 5) begin
          bus.req_vld[i] = 1'b0;
        end
      end
      bus.rsp_rdy = ($urandom_range(0, 99) < 70);
    end
    bus.req_vld = '0;
    bus.rsp_rdy = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_drain: got busy=%b expected 0", busy); end
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.req_vld  = '0;
    bus.req_in   = '0;
    bus.req_mode = '0;
    bus.req_op   = '0;
    bus.req_shift = '0;
    bus.rsp_rdy  = 1'b1;
    test_reset();
    test_single();
    test_sra();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
